// File: rtl/rambus_arbiter.sv
// Round-robin arbiter sharing the OpenRAM port B wishbone bus between N masters,
// with a stall watchdog that force-completes accesses a hung slave never acks.
module rambus_arbiter #(
  parameter int unsigned N_MASTERS  = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_ni,
  input  logic [N_MASTERS-1:0]             active_i,
  input  logic [N_MASTERS-1:0]             m_cyc_i,
  input  logic [N_MASTERS-1:0]             m_stb_i,
  input  logic [N_MASTERS-1:0]             m_we_i,
  input  logic [4*N_MASTERS-1:0]           m_sel_i,
  input  logic [32*N_MASTERS-1:0]          m_dat_i,
  input  logic [ADDR_WIDTH*N_MASTERS-1:0]  m_adr_i,
  output logic [N_MASTERS-1:0]             m_ack_o,
  output logic [32*N_MASTERS-1:0]          m_dat_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [3:0]                       s_sel_o,
  output logic [31:0]                      s_dat_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  input  logic                             s_ack_i,
  input  logic [31:0]                      s_dat_i,
  output logic [N_MASTERS-1:0]             grant_o,
  output logic                             timeout_o,
  input  logic                             timeout_clr_i
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      last_q;
  logic [7:0]           cnt_q;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] pick_oh;
  logic [IdxW-1:0]      pick;
  logic                 found;
  logic                 fire;
  logic                 g_cyc, g_stb, g_we;
  logic [3:0]           g_sel;
  logic [31:0]          g_dat;
  logic [ADDR_WIDTH-1:0] g_adr;

  // Round-robin pick: first requester strictly after last_q, else wrap from 0.
  always_comb begin
    req   = m_cyc_i & active_i;
    pick  = last_q;
    found = 1'b0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && req[i] && (IdxW'(i) > last_q)) begin
        pick  = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && req[i] && (IdxW'(i) <= last_q)) begin
        pick  = IdxW'(i);
        found = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  // Granted master's bus, selected by last_q (equal to the grantee while busy).
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_dat = '0;
    g_adr = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (IdxW'(i) == last_q) begin
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        g_we  = m_we_i[i];
        g_sel = m_sel_i[i*4 +: 4];
        g_dat = m_dat_i[i*32 +: 32];
        g_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_dat_o = '0;
    s_adr_o = '0;
    m_ack_o = '0;
    // Gated by g_cyc so the slave side goes quiet in the cycle cyc falls.
    if (state_q == StBusy && g_cyc) begin
      s_cyc_o = 1'b1;
      s_stb_o = g_stb;
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_dat_o = g_dat;
      s_adr_o = g_adr;
    end
    fire = s_stb_o && !s_ack_i && (cnt_q == 8'(TIMEOUT - 1));
    if (state_q == StBusy && (s_ack_i || fire)) begin
      m_ack_o = grant_o;
    end
    m_dat_o = {N_MASTERS{fire ? 32'hFFFF_FFFF : s_dat_i}};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      grant_o   <= '0;
      last_q    <= IdxW'(N_MASTERS - 1);
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (fire) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (|req) begin
            grant_o <= pick_oh;
            last_q  <= pick;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!g_cyc) begin
            grant_o <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (fire) begin
            cnt_q   <= '0;
            state_q <= StAbort;
          end else if (s_ack_i) begin
            cnt_q <= '0;
          end else if (s_stb_o) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StAbort: begin
          if (!g_cyc) begin
            grant_o <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Bench for rambus_arbiter: arbitration vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_rambus_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    act, cyc, stb, we, m_ack, grant;
  logic [4*N-1:0]  sel;
  logic [32*N-1:0] mdi, m_dat;
  logic [AW*N-1:0] adr;
  logic            s_cyc, s_stb, s_we, s_ack, tout, tclr;
  logic [3:0]      s_sel;
  logic [31:0]     sdo, s_dat;
  logic [AW-1:0]   s_adr;

  rambus_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .active_i(act),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel), .m_dat_i(mdi), .m_adr_i(adr),
    .m_ack_o(m_ack), .m_dat_o(m_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_dat_o(sdo),
    .s_adr_o(s_adr), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(grant), .timeout_o(tout), .timeout_clr_i(tclr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; act = '1; sel = '0; mdi = '0; adr = '0;
    tclr = 1'b0; s_ack = 1'b0; s_dat = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_m(input int i, input logic c, input logic w, input logic [AW-1:0] a);
    cyc[i] = c;
    stb[i] = c;
    we[i]  = w;
    adr[i*AW +: AW] = a;
    sel[i*4 +: 4]   = 4'hF;
    mdi[i*32 +: 32] = $urandom;
  endtask

  // Serve one ack to the granted master m, release, check the single idle cycle, re-request.
  task automatic serve(input int m);
    logic [31:0] d;
    logic [3:0]  oh;
    d  = $urandom;
    oh = 4'b0001 << m;
    chk("seq grant", grant, oh);
    chk("seq s_cyc", s_cyc, 1);
    s_ack = 1'b1; s_dat = d;
    #1;
    chk("seq m_ack", m_ack, oh);
    chk("seq m_dat", m_dat[m*32 +: 32], d);
    tick;
    s_ack = 1'b0; cyc[m] = 1'b0; stb[m] = 1'b0;
    #1;
    chk("seq release s_cyc", s_cyc, 0);
    tick;
    chk("seq idle gap", grant, 0);
    cyc[m] = 1'b1; stb[m] = 1'b1;
    tick;
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = N; k >= 1; k--) begin
      idx = 2'(int'(last) + k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] act;
    logic [3:0] grant;
  } vec_t;
  vec_t tbl[9];

  logic [1:0]  own, mlast;
  bit          own_v, aborted, tflag, deaf, ebusy, ecyc, estb, efire;
  int          stall;
  logic [3:0]  egrant, eack, prev_ack;
  logic [31:0] edat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 4'b1111, 4'b0001};
    tbl[1] = '{4'b0010, 4'b1111, 4'b0010};
    tbl[2] = '{4'b1100, 4'b1111, 4'b0100};
    tbl[3] = '{4'b1111, 4'b1110, 4'b0010};
    tbl[4] = '{4'b1000, 4'b1111, 4'b1000};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000};
    tbl[6] = '{4'b1111, 4'b0000, 4'b0000};
    tbl[7] = '{4'b1010, 4'b0011, 4'b0010};
    tbl[8] = '{4'b1100, 4'b0111, 4'b0100};

    do_reset;
    chk("reset grant", grant, 0);
    chk("reset s_cyc", s_cyc, 0);
    chk("reset m_ack", m_ack, 0);
    chk("reset timeout", tout, 0);

    // First arbitration after reset under various request/active patterns.
    for (int v = 0; v < 9; v++) begin
      do_reset;
      cyc = tbl[v].cyc; stb = tbl[v].cyc; act = tbl[v].act;
      tick;
      chk("table grant", grant, tbl[v].grant);
      chk("table s_cyc", s_cyc, |tbl[v].grant);
    end

    // Single master read.
    do_reset;
    set_m(1, 1'b1, 1'b0, 10'h004);
    tick;
    chk("single grant", grant, 4'b0010);
    chk("single s_adr", s_adr, 10'h004);
    chk("single s_we", s_we, 0);
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    #1;
    chk("single m_ack", m_ack, 4'b0010);
    chk("single m_dat", m_dat[63:32], 32'h1234_5678);
    tick;
    s_ack = 1'b0; cyc = '0; stb = '0;
    tick;
    chk("single release", grant, 0);

    // Round robin 0,1,2,3,0.
    do_reset;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, AW'(i));
    tick;
    serve(0); serve(1); serve(2); serve(3); serve(0);

    // Active mask 1101: order 0,2,3,0; dropping active[0] does not revoke.
    do_reset;
    act = 4'b1101;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, AW'(i));
    tick;
    serve(0); serve(2); serve(3);
    chk("mask grant0 again", grant, 4'b0001);
    act = 4'b1100;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("mask hold grant", grant, 4'b0001);
    end

    // Timeout, flag clear, and clear colliding with a new timeout.
    do_reset;
    set_m(2, 1'b1, 1'b0, 10'h3AB);
    tick;
    for (int c = 1; c <= T; c++) begin
      #1;
      chk("to m_ack", m_ack, (c == T) ? 4'b0100 : 4'b0000);
      chk("to flag pre", tout, 0);
      if (c == T) chk("to m_dat", m_dat[95:64], 32'hFFFF_FFFF);
      tick;
    end
    for (int c = 0; c < 2; c++) begin
      chk("to flag set", tout, 1);
      chk("abort s_cyc", s_cyc, 0);
      chk("abort s_stb", s_stb, 0);
      chk("abort m_ack", m_ack, 0);
      chk("abort grant", grant, 4'b0100);
      tick;
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick;
    chk("abort exit grant", grant, 0);
    tclr = 1'b1;
    tick;
    tclr = 1'b0;
    #1;
    chk("to clear", tout, 0);
    cyc[2] = 1'b1; stb[2] = 1'b1;
    tick;
    for (int c = 1; c <= T; c++) begin
      tclr = (c == T);
      #1;
      tick;
    end
    tclr = 1'b0;
    #1;
    chk("to set wins", tout, 1);

    // Burst hold by master 2 with master 0 waiting.
    do_reset;
    set_m(2, 1'b1, 1'b1, 10'h020);
    tick;
    set_m(0, 1'b1, 1'b0, 10'h001);
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1; s_dat = $urandom;
      adr[2*AW +: AW] = AW'(32 + b);
      #1;
      chk("burst grant", grant, 4'b0100);
      chk("burst s_we", s_we, 1);
      chk("burst m_ack", m_ack, 4'b0100);
      chk("burst s_adr", s_adr, AW'(32 + b));
      tick;
    end
    s_ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    #1;
    chk("burst drop s_cyc", s_cyc, 0);
    tick;
    chk("burst idle", grant, 0);
    tick;
    chk("burst next grant", grant, 4'b0001);

    // Reset mid-transfer.
    do_reset;
    set_m(3, 1'b1, 1'b1, 10'h155);
    tick;
    chk("rst pre grant", grant, 4'b1000);
    s_ack = 1'b1;
    #1;
    chk("rst pre m_ack", m_ack, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("rst s_cyc", s_cyc, 0);
    chk("rst s_stb", s_stb, 0);
    chk("rst grant", grant, 0);
    chk("rst m_ack", m_ack, 0);
    s_ack = 1'b0;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, AW'(i));
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("rst first grant", grant, 4'b0001);

    // Randomized traffic against the reference model.
    do_reset;
    tick;
    own_v = 0; aborted = 0; tflag = 0; stall = 0; own = '0; mlast = 2'd3; prev_ack = '0;
    for (int cy = 0; cy < 3000; cy++) begin
      for (int i = 0; i < N; i++) begin
        if (!cyc[i]) begin
          if ($urandom_range(3) == 0) set_m(i, 1'b1, 1'($urandom), AW'($urandom));
        end else if (prev_ack[i]) begin
          if ($urandom_range(1) == 0) set_m(i, 1'b0, 1'b0, '0);
          else set_m(i, 1'b1, 1'($urandom), AW'($urandom));
        end else if ($urandom_range(15) == 0) begin
          set_m(i, 1'b0, 1'b0, '0);
        end
      end
      if (cy % 16 == 0) act = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
      tclr  = ($urandom_range(15) == 0);
      deaf  = ((cy / 64) % 4) == 3;
      ebusy = own_v && !aborted;
      ecyc  = ebusy && cyc[own];
      estb  = ecyc && stb[own];
      s_ack = estb && !deaf && ($urandom_range(2) == 0);
      s_dat = $urandom;
      #1;
      efire  = estb && !s_ack && (stall == T - 1);
      egrant = own_v ? (4'b0001 << own) : 4'b0000;
      eack   = (ebusy && (s_ack || efire)) ? egrant : 4'b0000;
      edat   = efire ? 32'hFFFF_FFFF : s_dat;
      chk("rand grant", grant, egrant);
      chk("rand s_cyc", s_cyc, ecyc);
      chk("rand s_stb", s_stb, estb);
      chk("rand s_adr", s_adr, ecyc ? adr[own*AW +: AW] : '0);
      chk("rand s_dat_o", sdo, ecyc ? mdi[own*32 +: 32] : '0);
      chk("rand m_ack", m_ack, eack);
      chk("rand m_dat", m_dat[(cy % N)*32 +: 32], edat);
      chk("rand timeout", tout, tflag);
      prev_ack = eack;
      @(posedge clk);
      if (efire) tflag = 1;
      else if (tclr) tflag = 0;
      if (!own_v) begin
        if ((cyc & act) != 0) begin
          own = rr_pick(cyc & act, mlast);
          mlast = own; own_v = 1; stall = 0;
        end
      end else if (!aborted) begin
        if (!cyc[own]) own_v = 0;
        else if (efire) begin aborted = 1; stall = 0; end
        else if (s_ack) stall = 0;
        else if (stb[own]) stall++;
      end else if (!cyc[own]) begin
        own_v = 0; aborted = 0;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
